// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline enable/flush sequencer: FSM states and
// bit positions of the enable and flush bundles.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_LD_STALL = 2'd2,
        ST_MC_WAIT  = 2'd3
    } ctrl_state_e;

    localparam int REG_ZERO = 0;

    localparam int NUM_EN    = 5;
    localparam int EN_PC     = 0;
    localparam int EN_IF_ID  = 1;
    localparam int EN_ID_EX  = 2;
    localparam int EN_EX_MEM = 3;
    localparam int EN_MEM_WB = 4;

    localparam int NUM_FL    = 4;
    localparam int FL_IF_ID  = 0;
    localparam int FL_ID_EX  = 1;
    localparam int FL_EX_MEM = 2;
    localparam int FL_MEM_WB = 3;

    // Enable bundle with every register upstream of 'stage' frozen.
    function automatic logic [NUM_EN-1:0] hold_below(input int stage);
        logic [NUM_EN-1:0] m;
        for (int i = 0; i < NUM_EN; i++) begin
            m[i] = (i >= stage);
        end
        return m;
    endfunction

endpackage

// File: rtl/pipe_hazard_cmp.sv
// Load-use comparator: a load in EX whose destination is read by the
// instruction currently in ID.
module pipe_hazard_cmp
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs_a,
    input  logic [REG_AW-1:0] id_rs_b,
    input  logic              id_uses_a,
    input  logic              id_uses_b,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_we,
    output logic              hazard
);

    logic rd_live;
    logic hit_a;
    logic hit_b;

    // Writes to register 0 are discarded, so they never create a dependency.
    assign rd_live = ex_mem_read & ex_we & (ex_rd != REG_AW'(REG_ZERO));
    assign hit_a   = id_uses_a & (id_rs_a == ex_rd);
    assign hit_b   = id_uses_b & (id_rs_b == ex_rd);
    assign hazard  = rd_live & (hit_a | hit_b);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Enable/flush sequencer for the 5-stage filter pipe: load-use bubbles,
// branch squash, multi-cycle op hold with timeout, data-memory wait.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int LD_STALL_CYC = 1,
    parameter int MC_TIMEOUT   = 64,
    parameter int PERF_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] i_ID_RsA,
    input  logic [REG_AW-1:0] i_ID_RsB,
    input  logic              i_ID_UsesA,
    input  logic              i_ID_UsesB,
    input  logic [REG_AW-1:0] i_EX_Rd,
    input  logic              i_EX_MemRead,
    input  logic              i_EX_WE,
    input  logic              i_EX_Branch,
    input  logic              i_EX_Multi,
    input  logic              i_MC_Done,
    input  logic              i_Mem_Req,
    input  logic              i_Mem_Ready,
    output logic              o_EN_PC,
    output logic              o_EN_IF_ID,
    output logic              o_EN_ID_EX,
    output logic              o_EN_EX_MEM,
    output logic              o_EN_MEM_WB,
    output logic              o_Flush_IF_ID,
    output logic              o_Flush_ID_EX,
    output logic              o_Flush_EX_MEM,
    output logic              o_Flush_MEM_WB,
    output logic [PERF_W-1:0] o_Stall_Cnt,
    output logic              o_MC_Timeout
);

    localparam int TMR_W = $clog2(MC_TIMEOUT + 1);
    localparam int LDC_W = (LD_STALL_CYC > 2) ? $clog2(LD_STALL_CYC) : 1;

    ctrl_state_e       state_reg, state_next;
    logic [TMR_W-1:0]  mc_tmr_reg, mc_tmr_next;
    logic [LDC_W-1:0]  ld_cnt_reg, ld_cnt_next;
    logic [PERF_W-1:0] stall_cnt_reg;
    logic              timeout_reg;
    logic              timeout_set;
    logic [NUM_EN-1:0] en_vec;
    logic [NUM_FL-1:0] fl_vec;
    logic              hazard;
    logic              mem_wait;

    pipe_hazard_cmp #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .id_rs_a     (i_ID_RsA),
        .id_rs_b     (i_ID_RsB),
        .id_uses_a   (i_ID_UsesA),
        .id_uses_b   (i_ID_UsesB),
        .ex_rd       (i_EX_Rd),
        .ex_mem_read (i_EX_MemRead),
        .ex_we       (i_EX_WE),
        .hazard      (hazard)
    );

    assign mem_wait = i_Mem_Req & ~i_Mem_Ready;

    always_comb begin
        state_next  = state_reg;
        mc_tmr_next = mc_tmr_reg;
        ld_cnt_next = ld_cnt_reg;
        timeout_set = 1'b0;
        en_vec      = '1;
        fl_vec      = '0;

        if (state_reg == ST_INIT) begin
            fl_vec      = '1;
            mc_tmr_next = '0;
            ld_cnt_next = '0;
            state_next  = ST_RUN;
        end else if (mem_wait) begin
            // Whole pipe frozen; all sequencing state holds its value.
            en_vec = '0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (i_EX_Multi && !i_MC_Done) begin
                        en_vec            = hold_below(EN_EX_MEM);
                        fl_vec[FL_EX_MEM] = 1'b1;
                        mc_tmr_next       = TMR_W'(1);
                        state_next        = ST_MC_WAIT;
                    end else if (i_EX_Branch) begin
                        fl_vec[FL_IF_ID] = 1'b1;
                        fl_vec[FL_ID_EX] = 1'b1;
                    end else if (hazard) begin
                        en_vec           = hold_below(EN_ID_EX);
                        fl_vec[FL_ID_EX] = 1'b1;
                        if (LD_STALL_CYC > 1) begin
                            ld_cnt_next = LDC_W'(LD_STALL_CYC - 1);
                            state_next  = ST_LD_STALL;
                        end
                    end
                end
                ST_LD_STALL: begin
                    en_vec           = hold_below(EN_ID_EX);
                    fl_vec[FL_ID_EX] = 1'b1;
                    ld_cnt_next      = ld_cnt_reg - LDC_W'(1);
                    if (ld_cnt_reg == LDC_W'(1)) begin
                        state_next = ST_RUN;
                    end
                end
                ST_MC_WAIT: begin
                    if (i_MC_Done) begin
                        mc_tmr_next = '0;
                        state_next  = ST_RUN;
                    end else if (mc_tmr_reg == TMR_W'(MC_TIMEOUT)) begin
                        // Abort: drop the stuck op and the instruction behind it.
                        fl_vec[FL_EX_MEM] = 1'b1;
                        fl_vec[FL_ID_EX]  = 1'b1;
                        timeout_set       = 1'b1;
                        mc_tmr_next       = '0;
                        state_next        = ST_RUN;
                    end else begin
                        en_vec            = hold_below(EN_EX_MEM);
                        fl_vec[FL_EX_MEM] = 1'b1;
                        mc_tmr_next       = mc_tmr_reg + TMR_W'(1);
                    end
                end
                ST_INIT: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_INIT;
            mc_tmr_reg    <= '0;
            ld_cnt_reg    <= '0;
            stall_cnt_reg <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mc_tmr_reg <= mc_tmr_next;
            ld_cnt_reg <= ld_cnt_next;
            if (!en_vec[EN_PC] && (stall_cnt_reg != {PERF_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + PERF_W'(1);
            end
            if (timeout_set) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign o_EN_PC        = en_vec[EN_PC];
    assign o_EN_IF_ID     = en_vec[EN_IF_ID];
    assign o_EN_ID_EX     = en_vec[EN_ID_EX];
    assign o_EN_EX_MEM    = en_vec[EN_EX_MEM];
    assign o_EN_MEM_WB    = en_vec[EN_MEM_WB];
    assign o_Flush_IF_ID  = fl_vec[FL_IF_ID];
    assign o_Flush_ID_EX  = fl_vec[FL_ID_EX];
    assign o_Flush_EX_MEM = fl_vec[FL_EX_MEM];
    assign o_Flush_MEM_WB = fl_vec[FL_MEM_WB];
    assign o_Stall_Cnt    = stall_cnt_reg;
    assign o_MC_Timeout   = timeout_reg;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios plus random traffic, all
// cycles checked against a counter-based behavioural model.
module tb_pipeline_stall_ctrl;

    localparam int REG_AW  = 5;
    localparam int LD_CYC  = 2;
    localparam int MC_TMO  = 64;
    localparam int PERF_W  = 8;
    localparam int CNT_MAX = (1 << PERF_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [REG_AW-1:0] id_rs_a, id_rs_b, ex_rd;
    logic              id_uses_a, id_uses_b;
    logic              ex_memread, ex_we, ex_branch, ex_multi;
    logic              mc_done, mem_req, mem_ready;

    logic              o_EN_PC, o_EN_IF_ID, o_EN_ID_EX, o_EN_EX_MEM, o_EN_MEM_WB;
    logic              o_Flush_IF_ID, o_Flush_ID_EX, o_Flush_EX_MEM, o_Flush_MEM_WB;
    logic [PERF_W-1:0] o_Stall_Cnt;
    logic              o_MC_Timeout;

    logic [4:0] en_bus;
    logic [3:0] fl_bus;
    assign en_bus = {o_EN_MEM_WB, o_EN_EX_MEM, o_EN_ID_EX, o_EN_IF_ID, o_EN_PC};
    assign fl_bus = {o_Flush_MEM_WB, o_Flush_EX_MEM, o_Flush_ID_EX, o_Flush_IF_ID};

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(
        .REG_AW       (REG_AW),
        .LD_STALL_CYC (LD_CYC),
        .MC_TIMEOUT   (MC_TMO),
        .PERF_W       (PERF_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_ID_RsA       (id_rs_a),
        .i_ID_RsB       (id_rs_b),
        .i_ID_UsesA     (id_uses_a),
        .i_ID_UsesB     (id_uses_b),
        .i_EX_Rd        (ex_rd),
        .i_EX_MemRead   (ex_memread),
        .i_EX_WE        (ex_we),
        .i_EX_Branch    (ex_branch),
        .i_EX_Multi     (ex_multi),
        .i_MC_Done      (mc_done),
        .i_Mem_Req      (mem_req),
        .i_Mem_Ready    (mem_ready),
        .o_EN_PC        (o_EN_PC),
        .o_EN_IF_ID     (o_EN_IF_ID),
        .o_EN_ID_EX     (o_EN_ID_EX),
        .o_EN_EX_MEM    (o_EN_EX_MEM),
        .o_EN_MEM_WB    (o_EN_MEM_WB),
        .o_Flush_IF_ID  (o_Flush_IF_ID),
        .o_Flush_ID_EX  (o_Flush_ID_EX),
        .o_Flush_EX_MEM (o_Flush_EX_MEM),
        .o_Flush_MEM_WB (o_Flush_MEM_WB),
        .o_Stall_Cnt    (o_Stall_Cnt),
        .o_MC_Timeout   (o_MC_Timeout)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: init pending flag, extra load-stall cycles still owed, and
    // number of cycles the current multi-cycle op has been stalling (0 = none).
    bit m_valid = 0;
    bit m_init;
    int m_ld;
    int m_mc;
    int m_stall;
    bit m_tmo;

    function automatic void model_eval(output logic [4:0] en, output logic [3:0] fl,
                                       output bit n_init, output int n_ld,
                                       output int n_mc, output bit tmo_set);
        bit haz;
        haz = ex_memread && ex_we && (ex_rd != 0) &&
              ((id_uses_a && id_rs_a == ex_rd) || (id_uses_b && id_rs_b == ex_rd));
        n_init  = m_init;
        n_ld    = m_ld;
        n_mc    = m_mc;
        tmo_set = 1'b0;
        en      = 5'b11111;
        fl      = 4'b0000;
        if (m_init) begin
            fl     = 4'b1111;
            n_init = 1'b0;
        end else if (mem_req && !mem_ready) begin
            en = 5'b00000;
        end else if (m_mc > 0) begin
            if (mc_done) begin
                n_mc = 0;
            end else if (m_mc == MC_TMO) begin
                fl      = 4'b0110;
                tmo_set = 1'b1;
                n_mc    = 0;
            end else begin
                en   = 5'b11000;
                fl   = 4'b0100;
                n_mc = m_mc + 1;
            end
        end else if (m_ld > 0) begin
            en   = 5'b11100;
            fl   = 4'b0010;
            n_ld = m_ld - 1;
        end else if (ex_multi && !mc_done) begin
            en   = 5'b11000;
            fl   = 4'b0100;
            n_mc = 1;
        end else if (ex_branch) begin
            fl = 4'b0011;
        end else if (haz) begin
            en   = 5'b11100;
            fl   = 4'b0010;
            n_ld = LD_CYC - 1;
        end
    endfunction

    always @(posedge clk) begin
        logic [4:0] e_en;
        logic [3:0] e_fl;
        bit         n_init, tset;
        int         n_ld, n_mc;
        if (!rst_n) begin
            m_init  = 1'b1;
            m_ld    = 0;
            m_mc    = 0;
            m_stall = 0;
            m_tmo   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            model_eval(e_en, e_fl, n_init, n_ld, n_mc, tset);
            if (!e_en[0] && m_stall < CNT_MAX) m_stall = m_stall + 1;
            if (tset) m_tmo = 1'b1;
            m_init = n_init;
            m_ld   = n_ld;
            m_mc   = n_mc;
        end
    end

    always @(negedge clk) begin
        logic [4:0] e_en;
        logic [3:0] e_fl;
        bit         n_init, tset;
        int         n_ld, n_mc;
        if (m_valid) begin
            model_eval(e_en, e_fl, n_init, n_ld, n_mc, tset);
            vectors++;
            if (en_bus !== e_en || fl_bus !== e_fl ||
                int'(o_Stall_Cnt) != m_stall || o_MC_Timeout !== m_tmo) begin
                miscompares++;
                $display("FAIL cycle_check t=%0t: en %b want %b, flush %b want %b, stall_cnt %0d want %0d, timeout %b want %b",
                         $time, en_bus, e_en, fl_bus, e_fl, o_Stall_Cnt, m_stall, o_MC_Timeout, m_tmo);
            end
        end
    end

    task automatic check_lit(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end else begin
            $display("check %s: %0d", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_idle();
        id_rs_a = '0; id_rs_b = '0; ex_rd = '0;
        id_uses_a = 0; id_uses_b = 0; ex_memread = 0; ex_we = 0;
        ex_branch = 0; ex_multi = 0; mc_done = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        set_idle();
        do_reset(3);

        // Reset release: one INIT cycle with everything enabled and flushed.
        mid();
        check_lit("init_en", int'(en_bus), 5'b11111);
        check_lit("init_flush", int'(fl_bus), 4'b1111);
        tick();
        mid();
        check_lit("run_flush", int'(fl_bus), 0);
        check_lit("run_stall_cnt", int'(o_Stall_Cnt), 0);
        tick();

        // Load-use hazard: two bubble cycles at LD_STALL_CYC=2.
        ex_memread = 1; ex_we = 1; ex_rd = 3; id_rs_a = 3; id_uses_a = 1;
        mid();
        check_lit("ld_en_pc", int'(o_EN_PC), 0);
        check_lit("ld_flush_id_ex", int'(o_Flush_ID_EX), 1);
        tick();
        mid();
        check_lit("ld_second_en_if_id", int'(o_EN_IF_ID), 0);
        tick();
        set_idle();
        ex_memread = 1; ex_we = 1; ex_rd = 0; id_rs_a = 0; id_uses_a = 1;
        mid();
        check_lit("ld_rd0_en_pc", int'(o_EN_PC), 1);
        tick();

        // Branch together with a hazard: squash wins, no stall.
        ex_rd = 3; id_rs_b = 3; id_uses_a = 0; id_uses_b = 1; ex_branch = 1;
        mid();
        check_lit("br_en", int'(en_bus), 5'b11111);
        check_lit("br_flush", int'(fl_bus), 4'b0011);
        tick();
        set_idle();

        // Multi-cycle op finishing after 5 stall cycles.
        do_reset(2);
        tick();
        ex_multi = 1;
        mid();
        check_lit("mc_first_en", int'(en_bus), 5'b11000);
        tick();
        ex_multi = 0;
        repeat (4) tick();
        mc_done = 1;
        mid();
        check_lit("mc_done_en", int'(en_bus), 5'b11111);
        check_lit("mc_done_flush", int'(fl_bus), 0);
        tick();
        mc_done = 0;
        mid();
        check_lit("mc_stall_cnt", int'(o_Stall_Cnt), 5);
        tick();

        // Multi-cycle op that never completes: abort after 64 stall cycles.
        ex_multi = 1;
        tick();
        ex_multi = 0;
        repeat (63) tick();
        mid();
        check_lit("tmo_flush", int'(fl_bus), 4'b0110);
        check_lit("tmo_en", int'(en_bus), 5'b11111);
        check_lit("tmo_flag_before", int'(o_MC_Timeout), 0);
        tick();
        mid();
        check_lit("tmo_flag_after", int'(o_MC_Timeout), 1);
        check_lit("tmo_stall_cnt", int'(o_Stall_Cnt), 69);
        repeat (3) tick();
        mid();
        check_lit("tmo_sticky", int'(o_MC_Timeout), 1);
        tick();

        // Memory wait at timer 10 freezes the MC timer for 3 cycles.
        do_reset(2);
        tick();
        mid();
        check_lit("rst_clears_tmo", int'(o_MC_Timeout), 0);
        tick();
        ex_multi = 1;
        tick();
        ex_multi = 0;
        repeat (9) tick();
        mem_req = 1; mem_ready = 0;
        repeat (3) begin
            mid();
            check_lit("memwait_en", int'(en_bus), 0);
            tick();
        end
        mem_req = 0;
        repeat (54) tick();
        mid();
        check_lit("memwait_abort_flush", int'(fl_bus), 4'b0110);
        check_lit("memwait_stall_cnt", int'(o_Stall_Cnt), 67);
        tick();

        // Reset in the middle of MC_WAIT discards the op without a timeout.
        do_reset(1);
        tick();
        ex_multi = 1;
        tick();
        ex_multi = 0;
        repeat (2) tick();
        do_reset(1);
        mid();
        check_lit("midrst_init_flush", int'(fl_bus), 4'b1111);
        check_lit("midrst_tmo", int'(o_MC_Timeout), 0);
        tick();
        mid();
        check_lit("midrst_run_en", int'(en_bus), 5'b11111);
        tick();

        // Random traffic; slow-done phases provoke timeouts, stall count saturates.
        for (int i = 0; i < 4000; i++) begin
            int done_div;
            done_div   = ((i / 400) % 2 == 1) ? 90 : 3;
            rst_n      = ($urandom_range(0, 1499) != 0);
            id_rs_a    = REG_AW'($urandom_range(0, 3));
            id_rs_b    = REG_AW'($urandom_range(0, 3));
            ex_rd      = REG_AW'($urandom_range(0, 3));
            id_uses_a  = $urandom_range(0, 1) == 1;
            id_uses_b  = $urandom_range(0, 1) == 1;
            ex_memread = $urandom_range(0, 2) == 0;
            ex_we      = $urandom_range(0, 3) != 0;
            ex_branch  = $urandom_range(0, 7) == 0;
            ex_multi   = $urandom_range(0, 9) == 0;
            mc_done    = $urandom_range(0, done_div - 1) == 0;
            mem_req    = $urandom_range(0, 4) == 0;
            mem_ready  = $urandom_range(0, 1) == 1;
            tick();
        end
        rst_n = 1'b1;
        set_idle();
        mid();
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
